uart_bus_arbiter: RTL

Round-robin arbiter and access sequencer for the UART register bus (we, ce, adr, dat). It lets NREQ internal requesters share one UART and turns each granted request into a single, correctly timed bus cycle. Write data and read data use separate paths. Each access completes with a one-cycle ack to its owner. The block sits between the host-side masters and the UART.

---
 rtl/uart_bus_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/uart_bus_arbiter.sv
// Round-robin arbiter and access sequencer for the UART register bus.
// Each granted request becomes one registered bus cycle: ACCESS, an optional
// read wait of READ_WAIT cycles, then DONE with a one-cycle ack to its owner.
module uart_bus_arbiter #(
    parameter int NREQ      = 2,
    parameter int READ_WAIT = 0
) (
    input  logic              clk,
    input  logic              arst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_we,
    input  logic [2*NREQ-1:0] req_adr,
    input  logic [8*NREQ-1:0] req_wdat,
    output logic [NREQ-1:0]   ack,
    output logic [7:0]        rdat,
    output logic              busy,
    output logic              uart_we,
    output logic              uart_ce,
    output logic [1:0]        uart_adr,
    output logic [7:0]        uart_dat_o,
    output logic              uart_dat_oe,
    input  logic [7:0]        uart_dat_i
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

    state_t          r_state, w_next;
    logic [IW-1:0]   r_grant, r_last, w_win, w_idx;
    logic            w_any;
    logic            r_we;
    logic [1:0]      r_adr;
    logic [7:0]      r_wdat;
    logic [2:0]      r_wcnt;

    logic            w_sel_we;
    logic [1:0]      w_sel_adr;
    logic [7:0]      w_sel_wdat;
    logic            w_ce_n;
    logic            w_cap;
    logic [NREQ-1:0] w_ack_n;

    assign busy = (r_state != S_IDLE);

    // Round-robin winner: first set req bit searching upward from last_grant+1
    always_comb begin
        w_win = '0;
        w_any = 1'b0;
        w_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = IW'((int'(r_last) + k) % NREQ);
            if (!w_any && req[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

    // Next state, plus next values of the registered bus outputs
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_any) w_next = S_ACCESS;
            S_ACCESS: w_next = (!r_we && READ_WAIT > 0) ? S_WAIT : S_DONE;
            S_WAIT:   if (r_wcnt == 3'd0) w_next = S_DONE;
            default:  w_next = S_IDLE;
        endcase

        // In IDLE the request is latched on the same edge that enters ACCESS,
        // so the bus outputs must be built from the winner's live inputs.
        if (r_state == S_IDLE) begin
            w_sel_we   = req_we[w_win];
            w_sel_adr  = req_adr[{w_win, 1'b0} +: 2];
            w_sel_wdat = req_wdat[{w_win, 3'b000} +: 8];
        end else begin
            w_sel_we   = r_we;
            w_sel_adr  = r_adr;
            w_sel_wdat = r_wdat;
        end

        w_ce_n  = (w_next == S_ACCESS) || (w_next == S_WAIT);
        w_ack_n = (w_next == S_DONE) ? ({{(NREQ-1){1'b0}}, 1'b1} << r_grant) : '0;
        w_cap   = !r_we && (w_next == S_DONE) &&
                  ((r_state == S_ACCESS) || (r_state == S_WAIT));
    end

    // State register
    always_ff @(posedge clk) begin
        if (arst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Request latch, grant history, wait counter and registered outputs
    always_ff @(posedge clk) begin
        if (arst) begin
            r_grant     <= '0;
            r_last      <= IW'(NREQ - 1);
            r_we        <= 1'b0;
            r_adr       <= '0;
            r_wdat      <= '0;
            r_wcnt      <= '0;
            ack         <= '0;
            rdat        <= '0;
            uart_we     <= 1'b0;
            uart_ce     <= 1'b0;
            uart_adr    <= '0;
            uart_dat_o  <= '0;
            uart_dat_oe <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_any) begin
                r_grant <= w_win;
                r_we    <= w_sel_we;
                r_adr   <= w_sel_adr;
                r_wdat  <= w_sel_wdat;
            end
            if (r_state == S_DONE) r_last <= r_grant;

            if (r_state == S_ACCESS)
                r_wcnt <= 3'(READ_WAIT - 1);
            else if (r_state == S_WAIT && r_wcnt != 3'd0)
                r_wcnt <= r_wcnt - 3'd1;

            if (w_cap) rdat <= uart_dat_i;

            ack         <= w_ack_n;
            uart_ce     <= w_ce_n;
            uart_we     <= w_ce_n && w_sel_we;
            uart_dat_oe <= w_ce_n && w_sel_we;
            uart_adr    <= w_ce_n ? w_sel_adr : 2'b00;
            uart_dat_o  <= (w_ce_n && w_sel_we) ? w_sel_wdat : 8'h00;
        end
    end

endmodule
